// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the integer register file and its write-back scoreboard.
// Imported by the interface, the counter and the top.
package cpu_pkg;
   localparam int XLEN         = 32;
   localparam int NREGS        = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int CNT_W        = 2;
   localparam int MAX_INFLIGHT = 3;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Pipeline-side bundle for the register file: write-back, reads, issue/squash.
// master = pipeline stages, slave = register file.
interface reg_file_sb_if;
   import cpu_pkg::*;

   logic                  reg_write_en_in;
   logic [REG_ADDR_W-1:0] reg_write_addr_in;
   logic [XLEN-1:0]       reg_write_data_in;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  issue_en;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  squash_en;
   logic [REG_ADDR_W-1:0] squash_rd;
   logic                  sb_error;

   modport master (
      output reg_write_en_in, reg_write_addr_in, reg_write_data_in,
      output rs1_addr, rs2_addr, issue_en, issue_rd, squash_en, squash_rd,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
   );

   modport slave (
      input  reg_write_en_in, reg_write_addr_in, reg_write_data_in,
      input  rs1_addr, rs2_addr, issue_en, issue_rd, squash_en, squash_rd,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
   );
endinterface

// File: rtl/reg_file_sb_counter.sv
// Per-register in-flight write counter, saturating in both directions.
// err pulses in any cycle whose net update leaves the legal range.
module sb_counter
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec_w,
   input  logic             dec_s,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);
   logic [CNT_W:0]   up;
   logic [CNT_W:0]   dn;
   logic [CNT_W:0]   diff;
   logic [CNT_W-1:0] cnt_nx;

   always_comb begin
      up     = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
      dn     = {{CNT_W{1'b0}}, dec_w} + {{CNT_W{1'b0}}, dec_s};
      diff   = up - dn;
      cnt_nx = diff[CNT_W-1:0];
      err    = 1'b0;
      if (up < dn) begin
         cnt_nx = '0;
         err    = 1'b1;
      end else if (diff > (CNT_W+1)'(MAX_INFLIGHT)) begin
         cnt_nx = CNT_W'(MAX_INFLIGHT);
         err    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nx;
   end
endmodule

// File: rtl/reg_file_sb.sv
// RV32I integer register file with write-first bypass and a per-register
// write-back scoreboard used by decode to stall on unresolved RAW hazards.
module reg_file_sb
   import cpu_pkg::*;
(
   input logic          clk,
   input logic          rst,
   reg_file_sb_if.slave rf
);
   logic [XLEN-1:0]             regs [NREGS];
   logic [NREGS-1:0][CNT_W-1:0] cnt;
   logic [NREGS-1:0]            err;
   logic                        wr_hit;

   assign wr_hit = rf.reg_write_en_in && (rf.reg_write_addr_in != REG_ZERO);
   assign cnt[0] = '0;
   assign err[0] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_sb
      sb_counter u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (rf.issue_en && rf.issue_rd == REG_ADDR_W'(r)),
         .dec_w (rf.reg_write_en_in && rf.reg_write_addr_in == REG_ADDR_W'(r)),
         .dec_s (rf.squash_en && rf.squash_rd == REG_ADDR_W'(r)),
         .cnt   (cnt[r]),
         .err   (err[r])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[rf.reg_write_addr_in] <= rf.reg_write_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rf.sb_error <= 1'b0;
      else if (|err) rf.sb_error <= 1'b1;
   end

   // Releases landing this cycle; the same-cycle issue never counts here.
   function automatic logic [CNT_W:0] rel(logic hw, logic hs);
      return {{CNT_W{1'b0}}, hw} + {{CNT_W{1'b0}}, hs};
   endfunction

   always_comb begin
      rf.rs1_data = '0;
      rf.rs1_busy = 1'b0;
      if (!rst && rf.rs1_addr != REG_ZERO) begin
         rf.rs1_data = (wr_hit && rf.reg_write_addr_in == rf.rs1_addr)
                     ? rf.reg_write_data_in : regs[rf.rs1_addr];
         rf.rs1_busy = {1'b0, cnt[rf.rs1_addr]} != rel(
            rf.reg_write_en_in && rf.reg_write_addr_in == rf.rs1_addr,
            rf.squash_en && rf.squash_rd == rf.rs1_addr);
      end
   end

   always_comb begin
      rf.rs2_data = '0;
      rf.rs2_busy = 1'b0;
      if (!rst && rf.rs2_addr != REG_ZERO) begin
         rf.rs2_data = (wr_hit && rf.reg_write_addr_in == rf.rs2_addr)
                     ? rf.reg_write_data_in : regs[rf.rs2_addr];
         rf.rs2_busy = {1'b0, cnt[rf.rs2_addr]} != rel(
            rf.reg_write_en_in && rf.reg_write_addr_in == rf.rs2_addr,
            rf.squash_en && rf.squash_rd == rf.rs2_addr);
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// compared against an arithmetic model of registers and in-flight counts.
module tb_reg_file_sb;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   reg_file_sb_if bus ();

   reg_file_sb dut (
      .clk (clk),
      .rst (rst),
      .rf  (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] m_reg [32];
   int          m_cnt [32];
   bit          m_err;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = '0;
         m_cnt[i] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic is, input logic [4:0] ird,
                      input logic sq, input logic [4:0] srd);
      bus.reg_write_en_in   = we;
      bus.reg_write_addr_in = wa;
      bus.reg_write_data_in = wd;
      bus.issue_en          = is;
      bus.issue_rd          = ird;
      bus.squash_en         = sq;
      bus.squash_rd         = srd;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.reg_write_en_in && bus.reg_write_addr_in == a) return bus.reg_write_data_in;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      int r;
      if (a == 5'd0) return 1'b0;
      r = m_cnt[a];
      if (bus.reg_write_en_in && bus.reg_write_addr_in == a) r = r - 1;
      if (bus.squash_en && bus.squash_rd == a) r = r - 1;
      return r != 0;
   endfunction

   // Advance one edge, fold current inputs into the model, return at negedge.
   task automatic step();
      int n;
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         for (int r = 1; r < 32; r++) begin
            n = m_cnt[r];
            if (bus.issue_en && bus.issue_rd == 5'(r)) n = n + 1;
            if (bus.reg_write_en_in && bus.reg_write_addr_in == 5'(r)) n = n - 1;
            if (bus.squash_en && bus.squash_rd == 5'(r)) n = n - 1;
            if (n < 0) begin n = 0; m_err = 1'b1; end
            if (n > MAX_INFLIGHT) begin n = MAX_INFLIGHT; m_err = 1'b1; end
            m_cnt[r] = n;
         end
         if (bus.reg_write_en_in && bus.reg_write_addr_in != 5'd0)
            m_reg[bus.reg_write_addr_in] = bus.reg_write_data_in;
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd0;
      idle();
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0 || bus.sb_error !== 1'b0) begin
         failures++;
         $display("FAIL init_reset got data=%h busy=%b err=%b exp 0/0/0",
                  bus.rs1_data, bus.rs1_busy, bus.sb_error);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
         step();
      end
      drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      idle();
      #1;
      checks++;
      if (bus.rs1_data !== 32'hDEADBEEF || bus.rs1_busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_x5 got data=%h busy=%b exp deadbeef/1",
                  bus.rs1_data, bus.rs1_busy);
      end
      drv(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b0, 5'd0);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0 || bus.sb_error !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got data=%h busy=%b err=%b exp 0/0/0",
                  bus.rs1_data, bus.rs1_busy, bus.sb_error);
      end
      step();
      rst = 1'b0;
      idle();
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_x5 got data=%h busy=%b exp 0/0",
                  bus.rs1_data, bus.rs1_busy);
      end
   endtask

   task automatic test_write_read();
      pulse_reset();
      drv(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      idle();
      bus.rs1_addr = 5'd3;
      #1;
      checks++;
      if (bus.rs1_data !== 32'h12345678) begin
         failures++;
         $display("FAIL read_x3 got=%h exp=12345678", bus.rs1_data);
      end
      drv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
      bus.rs2_addr = 5'd0;
      #1;
      checks++;
      if (bus.rs2_data !== 32'h0 || bus.rs2_busy !== 1'b0) begin
         failures++;
         $display("FAIL x0_same got data=%h busy=%b exp 0/0", bus.rs2_data, bus.rs2_busy);
      end
      step();
      idle();
      #1;
      checks++;
      if (bus.rs2_data !== 32'h0 || bus.rs2_busy !== 1'b0) begin
         failures++;
         $display("FAIL x0_next got data=%h busy=%b exp 0/0", bus.rs2_data, bus.rs2_busy);
      end
   endtask

   task automatic test_bypass();
      pulse_reset();
      drv(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
      bus.rs1_addr = 5'd7;
      bus.rs2_addr = 5'd7;
      #1;
      checks++;
      if (bus.rs1_data !== 32'hA5A5A5A5 || bus.rs2_data !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL bypass got rs1=%h rs2=%h exp a5a5a5a5", bus.rs1_data, bus.rs2_data);
      end
      step();
   endtask

   task automatic test_stall_release();
      pulse_reset();
      bus.rs1_addr = 5'd9;
      drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
      step();
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_one got=%b exp=1", bus.rs1_busy);
      end
      step();
      drv(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_two got=%b exp=1", bus.rs1_busy);
      end
      step();
      drv(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'h2) begin
         failures++;
         $display("FAIL release got busy=%b data=%h exp 0/2", bus.rs1_busy, bus.rs1_data);
      end
      step();
      idle();
   endtask

   task automatic test_squash();
      pulse_reset();
      bus.rs1_addr = 5'd4;
      drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0);
      step();
      step();
      drv(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 5'd4);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0) begin
         failures++;
         $display("FAIL squash_same got=%b exp=0", bus.rs1_busy);
      end
      step();
      idle();
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.sb_error !== 1'b0) begin
         failures++;
         $display("FAIL squash_next got busy=%b err=%b exp 0/0", bus.rs1_busy, bus.sb_error);
      end
      drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0);
      step();
      drv(1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 1'b0, 5'd0);
      step();
      idle();
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b1 || bus.sb_error !== 1'b0) begin
         failures++;
         $display("FAIL issue_wb got busy=%b err=%b exp 1/0", bus.rs1_busy, bus.sb_error);
      end
   endtask

   task automatic test_error();
      pulse_reset();
      bus.rs1_addr = 5'd6;
      for (int k = 0; k < 4; k++) begin
         drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd0);
         step();
         #1;
         checks++;
         if (bus.sb_error !== (k == 3)) begin
            failures++;
            $display("FAIL overflow_k%0d got=%b exp=%b", k, bus.sb_error, k == 3);
         end
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 5'd6, 32'h60 + k, 1'b0, 5'd0, 1'b0, 5'd0);
         #1;
         checks++;
         if (bus.rs1_busy !== (k != 2)) begin
            failures++;
            $display("FAIL drain_k%0d got=%b exp=%b", k, bus.rs1_busy, k != 2);
         end
         step();
      end
      pulse_reset();
      drv(1'b1, 5'd8, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      idle();
      bus.rs1_addr = 5'd8;
      #1;
      checks++;
      if (bus.sb_error !== 1'b1 || bus.rs1_data !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL underflow got err=%b data=%h exp 1/cafef00d",
                  bus.sb_error, bus.rs1_data);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (i % 75 == 0) pulse_reset();
         drv(1'($urandom), 5'($urandom % 8), $urandom,
             1'($urandom), 5'($urandom % 8),
             ($urandom % 4) == 0, 5'($urandom % 8));
         bus.rs1_addr = 5'($urandom % 8);
         bus.rs2_addr = 5'($urandom % 8);
         #1;
         checks++;
         if (bus.rs1_data !== exp_data(bus.rs1_addr) ||
             bus.rs2_data !== exp_data(bus.rs2_addr)) begin
            failures++;
            $display("FAIL rnd_data i=%0d got %h/%h exp %h/%h", i, bus.rs1_data,
                     bus.rs2_data, exp_data(bus.rs1_addr), exp_data(bus.rs2_addr));
         end
         checks++;
         if (bus.rs1_busy !== exp_busy(bus.rs1_addr) ||
             bus.rs2_busy !== exp_busy(bus.rs2_addr)) begin
            failures++;
            $display("FAIL rnd_busy i=%0d got %b/%b exp %b/%b", i, bus.rs1_busy,
                     bus.rs2_busy, exp_busy(bus.rs1_addr), exp_busy(bus.rs2_addr));
         end
         checks++;
         if (bus.sb_error !== m_err) begin
            failures++;
            $display("FAIL rnd_err i=%0d got=%b exp=%b", i, bus.sb_error, m_err);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_bypass();
      test_stall_release();
      test_squash();
      test_error();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Integer register file with a write-back scoreboard for the 5-stage RV32I pipeline.
- Receiver end of the write-back interface: consumes the final write enable, address and data from the WB stage.
- Serves two combinational read ports to decode.
- Tracks outstanding writes per register so decode can stall on RAW hazards that forwarding cannot cover.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (x0..x31).
- CNT_W, 2, width of each per-register in-flight counter.
- MAX_INFLIGHT, 3, maximum legal outstanding writes per register (EX, MEM, WB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_write_en_in  in  1  write enable from WB stage.
- reg_write_addr_in  in  5  destination register from WB stage.
- reg_write_data_in  in  XLEN  write data from WB stage.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- rs1_busy  out  1  rs1 has an unresolved pending write.
- rs2_busy  out  1  rs2 has an unresolved pending write.
- issue_en  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  5  destination of the issued instruction.
- squash_en  in  1  an issued writer was killed (flush) and will never reach WB.
- squash_rd  in  5  destination of the squashed writer.
- sb_error  out  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (asynchronous, active-high, applies immediately):
  - All registers clear to 0.
  - All counters clear to 0.
  - sb_error clears to 0.
  - Hence rs*_data = 0 and rs*_busy = 0 while rst is high.
  - Reset mid-operation discards all pending state; no write completes in a cycle where rst is high.
- x0:
  - Reads return 0; busy is always 0.
  - Writes, issues and squashes addressed to x0 are ignored (no counter change, no error).
- Write:
  - When reg_write_en_in is high and addr != 0, the register updates on the rising edge.
  - Write latency is one edge.
- Read:
  - Combinational, zero latency.
  - Write-first bypass: if reg_write_en_in is high, addr != 0 and addr == rsN_addr, rsN_data = reg_write_data_in in the same cycle.
- Counter update per register r, on each edge:
  - cnt_next = cnt + inc - dec_w - dec_s.
  - inc = issue_en && issue_rd == r.
  - dec_w = reg_write_en_in && reg_write_addr_in == r.
  - dec_s = squash_en && squash_rd == r.
  - All three terms may hit the same register in one cycle; the net sum applies (range −2..+1).
- Busy:
  - rsN_busy = (cnt[rsN] − dec_w − dec_s) != 0 for the current cycle.
  - A release in the same cycle unblocks immediately: data comes from the bypass, or from the old value when squashed.
  - The same-cycle issue is excluded from busy, since the issuing instruction's own rd must not stall its own reads.
- Underflow: if the computed value is below 0, the counter holds 0 and sb_error sets.
- Overflow: if the computed value exceeds MAX_INFLIGHT, the counter saturates at MAX_INFLIGHT and sb_error sets.
- sb_error is sticky until rst.
- A WB write to a register whose counter is 0 counts as underflow. Data is still written.

Decomposition:
- Shared package (cpu_pkg) holds:
  - XLEN, NREGS, REG_ADDR_W = 5, CNT_W, MAX_INFLIGHT.
  - The REG_ZERO = 5'd0 constant.
- One natural sub-module: sb_counter. It is a single per-register saturating up/down counter with inc, dec_w, dec_s inputs, a cnt output and an err pulse. It is instantiated 31 times via generate; x0 has no counter.
- Storage and bypass muxes stay in the top module.

Test Plan:
1. Reset check: assert rst mid-run after writing x5 = 0xDEADBEEF with cnt[x5] = 2. Required: rs1_data = 0 and rs1_busy = 0 with rs1_addr = 5 immediately; sb_error = 0.
2. Write then read: write x3 = 0x12345678, then read rs1 = 3 next cycle → 0x12345678. Write x0 = 0xFFFFFFFF, then read rs2 = 0 → 0, busy = 0.
3. Same-cycle bypass: WB writes x7 = 0xA5A5A5A5 while rs1_addr = rs2_addr = 7 → both data = 0xA5A5A5A5 in the same cycle.
4. Scoreboard stall/release:
   - Issue rd = 9 → next cycle rs1_busy = 1 for rs1 = 9.
   - Issue rd = 9 again (cnt = 2), then WB writes x9 = 1 → busy stays 1 that cycle.
   - Second WB write x9 = 2 → busy = 0 that cycle, data = 2.
5. Squash and simultaneity:
   - Case A: cnt[x4] = 2; WB write x4 and squash rd = 4 in the same cycle → busy = 0 that cycle, cnt = 0 next, sb_error = 0.
   - Case B: issue rd = 4 with WB write x4 (cnt 1 → 1) → busy remains 1 next cycle.
6. Error flag:
   - Four issues to x6 without release → sb_error = 1 after the 4th edge, cnt = 3.
   - After reset, a WB write to x8 with cnt = 0 → sb_error = 1, x8 still updated.
